pmem_arbiter_adaptor: RTL and testbench
=======================================

# pmem_arbiter_adaptor

Parametrised successor to the single-channel cacheline adaptor. Sits between NUM_PORTS cache-side line requesters (e.g. split I-cache and D-cache) and the single burst-oriented physical memory port. Round-robin arbitrates whole-line requests, then serialises write lines into BURST_W beats or assembles read beats into a LINE_W line.

## Interface
Parameters:
- NUM_PORTS, 2, number of cache-side channels (>=1)
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width in bits; LINE_W % BURST_W == 0, BEATS = LINE_W/BURST_W >= 2
- ADDR_W, 32, address width

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- read_i  in  NUM_PORTS  per-port line read request, held until resp_o
- write_i  in  NUM_PORTS  per-port line write request, held until resp_o
- address_i  in  NUM_PORTS*ADDR_W  per-port line address, port p at [p*ADDR_W +: ADDR_W]
- line_i  in  NUM_PORTS*LINE_W  per-port write line
- line_o  out  LINE_W  read line, valid while resp_o is nonzero for a read
- resp_o  out  NUM_PORTS  one-hot completion pulse
- burst_i  in  BURST_W  memory read beat
- burst_o  out  BURST_W  memory write beat
- address_o  out  ADDR_W  line-aligned memory address
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat strobe

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: a port is requesting if read_i[p] | write_i[p]. Grant the first requesting port searching from (last_grant+1) mod NUM_PORTS upward. On grant, latch port index, op, address, and line_i of that port; clear beat counter; go to WRITE if write_i[p], else READ (write wins if both asserted on one port). No request: stay.
- READ: read_o=1. Each cycle with resp_i=1, store burst_i into line buffer beat slot cnt, cnt++. On resp_i with cnt==BEATS-1 go to DONE.
- WRITE: write_o=1, burst_o = latched line beat cnt. Each resp_i=1 consumes the beat, cnt++. On resp_i with cnt==BEATS-1 go to DONE.
- DONE: resp_o[grant]=1 for exactly one cycle, read_o=write_o=0, line_o = assembled buffer; update last_grant=grant; go to IDLE.
- Beat order: beat k occupies line bits [k*BURST_W +: BURST_W], beat 0 first.
- address_o = latched address with low log2(LINE_W/8) bits forced to 0; held constant from grant through DONE.
- Requesters drop read_i/write_i in the cycle after their resp_o; IDLE never sees a stale request.
- resp_i in IDLE or DONE is ignored; requests arriving mid-transaction wait.
- line_o holds its last value outside DONE; resp_o for a write also pulses (line_o then undefined to user).

## Timing
- Reset (async, reset_n=0): state IDLE, cnt=0, last_grant=NUM_PORTS-1 (port 0 wins first), read_o=write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0. Reset mid-transaction abandons it; memory model must be reset concurrently.
- Request visible at edge N in IDLE -> read_o/write_o high from cycle N+1.
- Last resp_i beat at cycle M -> resp_o at cycle M+1, read_o/write_o low at M+1.
- Minimum line latency with back-to-back resp_i from cycle N+1: BEATS+1 cycles request-to-resp_o; next grant earliest 2 cycles after resp_o (DONE, then IDLE decision).
- Non-consecutive resp_i beats allowed; request held and counter frozen on resp_i=0 cycles.
- read_o/write_o and burst_o are registered-state decodes, glitch-free relative to clk.

## Test plan
- Single read, port 0, address 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> address_o=0x0000_1220, read_o 4 cycles, resp_o=2'b01 one cycle, line_o = {beat3,beat2,beat1,beat0}.
- Single write, port 1, line_i = 256'h(DDDD..CCCC..BBBB..AAAA), resp_i with gaps -> burst_o sequence AAAA,BBBB,CCCC,DDDD each held until its resp_i, resp_o=2'b10 after last beat.
- Both ports request continuously from reset -> grants alternate 0,1,0,1; each resp_o one-hot, no double grant.
- read_i and write_i both high on port 0 -> write performed, write_o asserted, read_o never.
- reset_n pulled low during beat 2 of a read -> all outputs 0 asynchronously; after release, new request to port 1 completes normally with correct line.
- resp_i strobed in IDLE with no request -> no state change, resp_o stays 0.

Source files
------------

// File: rtl/pmem_arbiter_adaptor.sv
// Round-robin arbiter in front of a burst memory port. Whole-line requests from
// NUM_PORTS requesters are granted one at a time. Write lines are serialised into
// BURST_W beats, and read beats are assembled back into a LINE_W line.
module pmem_arbiter_adaptor #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned BURST_W   = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        read_i,
  input  logic [NUM_PORTS-1:0]        write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] address_i,
  input  logic [NUM_PORTS*LINE_W-1:0] line_i,
  output logic [LINE_W-1:0]           line_o,
  output logic [NUM_PORTS-1:0]        resp_o,
  input  logic [BURST_W-1:0]          burst_i,
  output logic [BURST_W-1:0]          burst_o,
  output logic [ADDR_W-1:0]           address_o,
  output logic                        read_o,
  output logic                        write_o,
  input  logic                        resp_i
);

  localparam int unsigned Beats = LINE_W / BURST_W;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned OffW  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] AlignMask = ~((ADDR_W'(1) << OffW) - ADDR_W'(1));

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [PortW-1:0]   grant_q;
  logic [PortW-1:0]   last_grant_q;
  logic [LINE_W-1:0]  buf_q;
  logic [LINE_W-1:0]  line_q;
  logic [BURST_W-1:0] burst_q;
  logic [ADDR_W-1:0]  address_q;
  logic               read_q;
  logic               write_q;
  logic [NUM_PORTS-1:0] resp_q;

  logic [NUM_PORTS-1:0] req;
  logic                 found;
  logic [PortW-1:0]     pick;
  logic [LINE_W-1:0]    pick_line;
  logic [ADDR_W-1:0]    pick_addr;
  logic                 pick_wr;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic [LINE_W-1:0]    buf_merged;
  logic [BURST_W-1:0]   next_beat;
  logic                 last_beat;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    req   = read_i | write_i;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      if (!found && req[(int'(last_grant_q) + i) % int'(NUM_PORTS)]) begin
        found = 1'b1;
        pick  = PortW'((int'(last_grant_q) + i) % int'(NUM_PORTS));
      end
    end
  end

  // Select the candidate port's address, line and op; decode the active grant.
  always_comb begin
    pick_line    = '0;
    pick_addr    = '0;
    pick_wr      = 1'b0;
    grant_onehot = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (pick == PortW'(p)) begin
        pick_line = line_i[p*LINE_W +: LINE_W];
        pick_addr = address_i[p*ADDR_W +: ADDR_W];
        pick_wr   = write_i[p];
      end
      if (grant_q == PortW'(p)) begin
        grant_onehot[p] = 1'b1;
      end
    end
  end

  // Beat slot views of the line buffer for the current counter.
  always_comb begin
    buf_merged = buf_q;
    buf_merged[cnt_q*BURST_W +: BURST_W] = burst_i;
    next_beat  = buf_q[(cnt_q + CntW'(1))*BURST_W +: BURST_W];
    last_beat  = (cnt_q == CntW'(Beats - 1));
  end

  // Transaction FSM; every output is a register updated on the transition that defines it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= PortW'(NUM_PORTS - 1);
      buf_q        <= '0;
      line_q       <= '0;
      burst_q      <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q   <= pick;
            cnt_q     <= '0;
            address_q <= pick_addr & AlignMask;
            buf_q     <= pick_line;
            burst_q   <= pick_line[BURST_W-1:0];
            // Write wins when a port raises both read and write.
            if (pick_wr) begin
              state_q <= StWrite;
              write_q <= 1'b1;
            end else begin
              state_q <= StRead;
              read_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (resp_i) begin
            buf_q <= buf_merged;
            cnt_q <= last_beat ? '0 : cnt_q + CntW'(1);
            if (last_beat) begin
              line_q  <= buf_merged;
              read_q  <= 1'b0;
              resp_q  <= grant_onehot;
              state_q <= StDone;
            end
          end
        end
        StWrite: begin
          if (resp_i) begin
            cnt_q <= last_beat ? '0 : cnt_q + CntW'(1);
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= grant_onehot;
              state_q <= StDone;
            end else begin
              burst_q <= next_beat;
            end
          end
        end
        StDone: begin
          resp_q       <= '0;
          last_grant_q <= grant_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign burst_o   = burst_q;
  assign address_o = address_q;
  assign read_o    = read_q;
  assign write_o   = write_q;

endmodule

// File: tb/tb_pmem_arbiter_adaptor.sv
// Scoreboard bench: requesters push expected completions per port, a memory
// model records what crossed the burst port, and a monitor pairs both on resp_o.
module tb_pmem_arbiter_adaptor;

  localparam int NP = 2;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int BEATS = LW / BW;
  localparam logic [31:0] AMASK = 32'hFFFF_FFE0;

  logic             clk;
  logic             reset_n;
  logic [NP-1:0]    read_i;
  logic [NP-1:0]    write_i;
  logic [NP*AW-1:0] address_i;
  logic [NP*LW-1:0] line_i;
  logic [LW-1:0]    line_o;
  logic [NP-1:0]    resp_o;
  logic [BW-1:0]    burst_i;
  logic [BW-1:0]    burst_o;
  logic [AW-1:0]    address_o;
  logic             read_o;
  logic             write_o;
  logic             resp_i;

  pmem_arbiter_adaptor #(
    .NUM_PORTS(NP), .LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [LW-1:0] line;
    bit          stable;
  } rec_t;

  rec_t exp0_q[$];
  rec_t exp1_q[$];
  rec_t mem_q[$];
  int   order_q[$];

  int checks = 0;
  int failures = 0;
  int strobe_pct = 100;
  int idle_pct = 0;
  int beat = 0;
  int both_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic void check(bit ok, string name, logic [LW-1:0] act, logic [LW-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Memory content is a pure function of line address and beat index.
  function automatic logic [BW-1:0] beat_data(logic [31:0] a, int k);
    return {a, 16'hC0DE, 16'(k)};
  endfunction

  function automatic logic [LW-1:0] read_model(logic [31:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = beat_data(a, k);
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Burst memory model: strobes randomly, serves reads, collects write beats.
  initial begin
    logic [LW-1:0] wacc;
    logic [31:0]   taddr;
    bit            stable;
    rec_t          r;
    wacc = '0; taddr = '0; stable = 1'b1;
    resp_i = 1'b0;
    burst_i = '0;
    forever begin
      @(negedge clk);
      resp_i = 1'b0;
      if (!reset_n) begin
        beat = 0;
      end else if (read_o || write_o) begin
        if (read_o && write_o) both_err++;
        if ($urandom_range(99) < strobe_pct) begin
          if (beat == 0) begin
            taddr = address_o;
            stable = 1'b1;
          end else if (address_o != taddr) begin
            stable = 1'b0;
          end
          resp_i = 1'b1;
          if (read_o) burst_i = beat_data(address_o, beat);
          else wacc[beat*BW +: BW] = burst_o;
          beat++;
          if (beat == BEATS) begin
            r.wr = write_o; r.addr = taddr; r.line = wacc; r.stable = stable;
            mem_q.push_back(r);
            beat = 0;
          end
        end
      end else if ($urandom_range(99) < idle_pct) begin
        resp_i = 1'b1;
      end
    end
  end

  // Monitor: pair each completion with the port's expectation and the memory record.
  initial begin
    logic [NP-1:0] prev_resp;
    rec_t e, m;
    int   p, o;
    bit   have;
    prev_resp = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_resp = '0;
      end else begin
        if (prev_resp != '0) check(resp_o == '0, "resp_single_cycle", LW'(resp_o), '0);
        if (resp_o != '0) begin
          check($onehot(resp_o), "resp_onehot", LW'(resp_o), '0);
          p = resp_o[1] ? 1 : 0;
          if (order_q.size() > 0) begin
            o = order_q.pop_front();
            check(p == o, "grant_order", LW'(p), LW'(o));
          end
          have = (p == 0) ? (exp0_q.size() > 0) : (exp1_q.size() > 0);
          check(have && mem_q.size() > 0, "resp_expected", LW'(resp_o), '0);
          if (have && mem_q.size() > 0) begin
            e = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            m = mem_q.pop_front();
            check(m.wr == e.wr, "op", LW'(m.wr), LW'(e.wr));
            check(m.addr == e.addr, "address_o", LW'(m.addr), LW'(e.addr));
            check(m.stable, "address_stable", LW'(m.stable), LW'(1));
            if (e.wr) check(m.line == e.line, "write_beats", m.line, e.line);
            else check(line_o == e.line, "read_line", line_o, e.line);
          end
        end
        prev_resp = resp_o;
      end
    end
  end

  // Issue one line request from port p (called at a negedge), wait for its resp_o.
  task automatic do_txn(input int p, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [LW-1:0] l, output int lat);
    rec_t e;
    bit got;
    e.wr = wr;
    e.addr = a & AMASK;
    e.line = wr ? l : read_model(a & AMASK);
    e.stable = 1'b1;
    if (p == 0) exp0_q.push_back(e);
    else exp1_q.push_back(e);
    address_i[p*AW +: AW] = a;
    line_i[p*LW +: LW] = l;
    read_i[p] = rd;
    write_i[p] = wr;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      got = resp_o[p];
    end
    check(got, "resp_timeout", LW'(got), LW'(1));
    read_i[p] = 1'b0;
    write_i[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic port_random(input int p, input int n, input int maxgap);
    int lat;
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(2);
      repeat ($urandom_range(maxgap)) @(negedge clk);
      do_txn(p, op != 1, op != 0, $urandom, rand_line(), lat);
    end
  endtask

  initial begin
    int lat;
    bit got;
    logic [LW-1:0] wline;
    read_i = '0; write_i = '0; address_i = '0; line_i = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check(!read_o && !write_o, "reset_req", LW'({read_o, write_o}), '0);
    check(resp_o == '0, "reset_resp", LW'(resp_o), '0);
    check(address_o == '0, "reset_address", LW'(address_o), '0);
    check(burst_o == '0, "reset_burst", LW'(burst_o), '0);
    check(line_o == '0, "reset_line", line_o, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Strobes with nobody requesting must be ignored.
    idle_pct = 100;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check(resp_o == '0 && !read_o && !write_o, "idle_strobe",
            LW'({resp_o, read_o, write_o}), '0);
    end
    idle_pct = 0;
    @(negedge clk);

    // Single read, back-to-back beats: BEATS+1 cycles to resp_o.
    strobe_pct = 100;
    do_txn(0, 1'b1, 1'b0, 32'h0000_1234, '0, lat);
    check(lat == BEATS + 1, "read_latency", LW'(lat), LW'(BEATS + 1));

    // Single write from port 1 with gapped strobes.
    strobe_pct = 50;
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_txn(1, 1'b0, 1'b1, 32'h0000_8040, wline, lat);

    // Read and write together on one port: the write is performed.
    strobe_pct = 70;
    do_txn(0, 1'b1, 1'b1, 32'h1357_9BDF, rand_line(), lat);

    // Reset in the middle of a read is abandoned; port 1 then completes normally.
    strobe_pct = 100;
    address_i[AW-1:0] = 32'h0000_4444;
    read_i[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      got = (beat == 2);
    end
    check(got, "reset_setup", LW'(got), LW'(1));
    #2 reset_n = 1'b0;
    #1;
    check(!read_o && !write_o && resp_o == '0, "async_reset_ctrl",
          LW'({resp_o, read_o, write_o}), '0);
    check(address_o == '0 && burst_o == '0 && line_o == '0, "async_reset_data",
          LW'(address_o), '0);
    read_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(1, 1'b1, 1'b0, 32'hABCD_EF17, '0, lat);

    // Both ports requesting continuously alternate; port 1 finished last.
    order_q.push_back(0); order_q.push_back(1);
    order_q.push_back(0); order_q.push_back(1);
    fork
      port_random(0, 2, 0);
      port_random(1, 2, 0);
    join
    check(order_q.size() == 0, "order_drained", LW'(order_q.size()), '0);

    // Randomised traffic on both ports.
    strobe_pct = 60;
    idle_pct = 30;
    fork
      port_random(0, 12, 3);
      port_random(1, 12, 3);
    join

    repeat (10) @(negedge clk);
    check(exp0_q.size() == 0 && exp1_q.size() == 0, "scoreboard_empty",
          LW'(exp0_q.size() + exp1_q.size()), '0);
    check(mem_q.size() == 0, "memory_records_empty", LW'(mem_q.size()), '0);
    check(both_err == 0, "read_and_write_together", LW'(both_err), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
